ifetch_sequencer: RTL and testbench

Multi-cycle instruction-fetch and PC sequencer that sits in front of the single-cycle execute stage. It fetches instructions from a wait-stated instruction memory over a req/ready handshake and issues each one to decode/execute as a one-cycle pulse. It then resolves the next PC from the execute stage's `Zero`/`Addr_Result` and the controller's jump/branch flags. It also provides `PC_plus_4` to the execute stage and the `jal` link address to the register file.

---
 rtl/ifetch_sequencer_if.sv | 22 ++
 rtl/ifetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_ifetch_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ifetch_sequencer_if.sv
// Instruction-memory read port: request/address out, ready/data back.
// The sequencer is the master; the memory model or bus adapter is the slave.
interface ifetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/ifetch_sequencer.sv
// ifetch_sequencer: multi-cycle fetch / PC sequencer in front of a
// single-cycle execute stage. Fetches over a req/ready handshake, issues each
// instruction as a one-cycle instr_valid pulse, then resolves the next PC
// from jr/jump/branch flags sampled during that issue cycle.
// Optional: define IFETCH_TIMEOUT_EN to add a fetch wait-cycle watchdog that
// parks the sequencer in a sticky ERROR state (left only by reset).
module ifetch_sequencer #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 255
) (
    input  logic                       clock,
    input  logic                       rst_n,
    input  logic                       stall,
    ifetch_sequencer_if.master         imem,
    output logic [31:0]                Instruction,
    output logic                       instr_valid,
    output logic [31:0]                pc,
    output logic [31:0]                PC_plus_4,
    input  logic [31:0]                Addr_Result,
    input  logic                       Zero,
    input  logic [31:0]                Read_data_1,
    input  logic                       Branch,
    input  logic                       nBranch,
    input  logic                       Jmp,
    input  logic                       Jal,
    input  logic                       Jr,
    output logic [31:0]                link_addr,
    output logic                       fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_ISSUE = 3'd2,
        S_HOLD  = 3'd3
`ifdef IFETCH_TIMEOUT_EN
        , S_ERROR = 3'd4
`endif
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_link;
    logic [31:0] w_pc_next;
    logic [31:0] w_pc_plus_4;
    logic        w_taken;

    // Low two bits of the jr source are discarded by word alignment.
    logic w_unused_ok;
    assign w_unused_ok = &{1'b0, Read_data_1[1:0]};

    assign w_pc_plus_4 = r_pc + 32'd4;
    assign w_taken     = (Branch & Zero) | (nBranch & ~Zero);

`ifdef IFETCH_TIMEOUT_EN
    localparam logic [15:0] TMO = FETCH_TIMEOUT[15:0];
    logic [15:0] r_wait_cnt;
    logic [15:0] w_wait_inc;
    assign w_wait_inc = r_wait_cnt + 16'd1;

    // Count FETCH cycles without ready; cleared whenever we are outside FETCH
    // so every fetch starts from zero.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_wait_cnt <= '0;
        else if (r_state != S_FETCH)
            r_wait_cnt <= '0;
        else if (!imem.imem_ready)
            r_wait_cnt <= w_wait_inc;
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state logic; stall is only consulted outside FETCH so an
    // in-flight request always completes. Ready wins over the timeout.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (!stall) w_next = S_FETCH;
            S_FETCH: begin
                if (imem.imem_ready)
                    w_next = S_ISSUE;
`ifdef IFETCH_TIMEOUT_EN
                else if (w_wait_inc >= TMO)
                    w_next = S_ERROR;
`endif
            end
            S_ISSUE: w_next = stall ? S_HOLD : S_FETCH;
            S_HOLD:  if (!stall) w_next = S_FETCH;
`ifdef IFETCH_TIMEOUT_EN
            S_ERROR: w_next = S_ERROR;
`endif
            default: w_next = S_IDLE;
        endcase
    end

    // Outputs decoded purely from registered state (no input-to-output path).
    always_comb begin
        imem.imem_req = (r_state == S_FETCH);
        instr_valid   = (r_state == S_ISSUE);
`ifdef IFETCH_TIMEOUT_EN
        fetch_err     = (r_state == S_ERROR);
`else
        fetch_err     = 1'b0;
`endif
    end

    // Next-PC priority: jr, then j/jal pseudo-direct, then taken branch.
    always_comb begin
        w_pc_next = w_pc_plus_4;
        if (Jr)
            w_pc_next = {Read_data_1[31:2], 2'b00};
        else if (Jmp | Jal)
            w_pc_next = {w_pc_plus_4[31:28], r_instr[25:0], 2'b00};
        else if (w_taken)
            w_pc_next = Addr_Result;
    end

    // Datapath registers: capture fetch data, advance PC and link on issue exit.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= {RESET_PC[31:2], 2'b00};
            r_instr <= '0;
            r_link  <= '0;
        end else begin
            if (r_state == S_FETCH && imem.imem_ready)
                r_instr <= imem.imem_rdata;
            if (r_state == S_ISSUE) begin
                r_pc <= w_pc_next;
                if (Jal)
                    r_link <= w_pc_plus_4;
            end
        end
    end

    assign imem.imem_addr = r_pc;
    assign pc             = r_pc;
    assign PC_plus_4      = w_pc_plus_4;
    assign Instruction    = r_instr;
    assign link_addr      = r_link;

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed, table-driven bench for ifetch_sequencer. Each vector drives one
// cycle of inputs and lists the outputs expected just after that edge.
module tb_ifetch_sequencer;

    logic        clock;
    logic        rst_n;
    logic        stall;
    logic [31:0] Instruction;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] PC_plus_4;
    logic [31:0] Addr_Result;
    logic        Zero;
    logic [31:0] Read_data_1;
    logic        Branch, nBranch, Jmp, Jal, Jr;
    logic [31:0] link_addr;
    logic        fetch_err;

    int checks = 0;
    int errors = 0;

    ifetch_sequencer_if imem_if();

    ifetch_sequencer #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(4)) dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .stall       (stall),
        .imem        (imem_if),
        .Instruction (Instruction),
        .instr_valid (instr_valid),
        .pc          (pc),
        .PC_plus_4   (PC_plus_4),
        .Addr_Result (Addr_Result),
        .Zero        (Zero),
        .Read_data_1 (Read_data_1),
        .Branch      (Branch),
        .nBranch     (nBranch),
        .Jmp         (Jmp),
        .Jal         (Jal),
        .Jr          (Jr),
        .link_addr   (link_addr),
        .fetch_err   (fetch_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] stall, ready, rdata;
        logic [31:0] br, nbr, jmp, jal, jr, zero, ares, rd1;
        logic [31:0] e_req, e_vld, e_pc, e_ins, e_lnk, e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic [31:0] s, logic [31:0] r, logic [31:0] d,
        logic [31:0] br, logic [31:0] nbr, logic [31:0] jmp, logic [31:0] jal,
        logic [31:0] jr, logic [31:0] z, logic [31:0] ar, logic [31:0] rd1,
        logic [31:0] req, logic [31:0] vld, logic [31:0] epc,
        logic [31:0] ins, logic [31:0] lnk, logic [31:0] err);
        vec_t v;
        v.stall = s;  v.ready = r;  v.rdata = d;
        v.br = br; v.nbr = nbr; v.jmp = jmp; v.jal = jal; v.jr = jr;
        v.zero = z; v.ares = ar; v.rd1 = rd1;
        v.e_req = req; v.e_vld = vld; v.e_pc = epc;
        v.e_ins = ins; v.e_lnk = lnk; v.e_err = err;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, then compare registered outputs 1ns after the edge.
    task automatic apply(string tag, vec_t v);
        stall               = v.stall[0];
        imem_if.imem_ready  = v.ready[0];
        imem_if.imem_rdata  = v.rdata;
        Branch = v.br[0];  nBranch = v.nbr[0]; Jmp = v.jmp[0];
        Jal    = v.jal[0]; Jr      = v.jr[0];  Zero = v.zero[0];
        Addr_Result = v.ares; Read_data_1 = v.rd1;
        @(posedge clock);
        #1;
        chk({tag, " req"},   {31'd0, imem_if.imem_req}, v.e_req);
        chk({tag, " valid"}, {31'd0, instr_valid},      v.e_vld);
        chk({tag, " pc"},    pc,                        v.e_pc);
        chk({tag, " pc4"},   PC_plus_4,                 v.e_pc + 32'd4);
        chk({tag, " instr"}, Instruction,               v.e_ins);
        chk({tag, " link"},  link_addr,                 v.e_lnk);
        chk({tag, " err"},   {31'd0, fetch_err},        v.e_err);
        if (v.e_req[0])
            chk({tag, " addr"}, imem_if.imem_addr, v.e_pc);
    endtask

    localparam logic [31:0] JAL_I = 32'h0C00_0010;

    initial begin
        vec_t h;
        // stall ready rdata | br nbr jmp jal jr zero ares rd1 | req vld pc instr link err
        tbl.push_back(mk(0,0,0,            0,0,0,0,0,0,0,0, 1,0,32'h0,32'h0,0,0));
        tbl.push_back(mk(0,1,32'hAAAA0001, 0,0,0,0,0,0,0,0, 0,1,32'h0,32'hAAAA0001,0,0));
        tbl.push_back(mk(0,0,0,            0,0,0,0,0,0,0,0, 1,0,32'h4,32'hAAAA0001,0,0));
        tbl.push_back(mk(0,1,32'hBBBB0002, 0,0,0,0,0,0,0,0, 0,1,32'h4,32'hBBBB0002,0,0));
        tbl.push_back(mk(0,0,0,            0,0,0,0,0,0,0,0, 1,0,32'h8,32'hBBBB0002,0,0));
        // three wait cycles; rdata garbage must not be captured
        tbl.push_back(mk(0,0,32'hDEADBEEF, 0,0,0,0,0,0,0,0, 1,0,32'h8,32'hBBBB0002,0,0));
        tbl.push_back(mk(0,0,32'hDEADBEEF, 0,0,0,0,0,0,0,0, 1,0,32'h8,32'hBBBB0002,0,0));
        tbl.push_back(mk(0,0,32'hDEADBEEF, 0,0,0,0,0,0,0,0, 1,0,32'h8,32'hBBBB0002,0,0));
        tbl.push_back(mk(0,1,32'hCCCC0003, 0,0,0,0,0,0,0,0, 0,1,32'h8,32'hCCCC0003,0,0));
        // beq taken to 0x40
        tbl.push_back(mk(0,0,0,            1,0,0,0,0,1,32'h40,0, 1,0,32'h40,32'hCCCC0003,0,0));
        tbl.push_back(mk(0,1,32'h00000011, 0,0,0,0,0,0,0,0, 0,1,32'h40,32'h00000011,0,0));
        // bne with Zero=1: not taken
        tbl.push_back(mk(0,0,0,            0,1,0,0,0,1,32'h80,0, 1,0,32'h44,32'h00000011,0,0));
        tbl.push_back(mk(0,1,JAL_I,        0,0,0,0,0,0,0,0, 0,1,32'h44,JAL_I,0,0));
        // jr beats jmp; low bits of rs dropped
        tbl.push_back(mk(0,0,0,            0,0,1,0,1,0,0,32'h10000023, 1,0,32'h10000020,JAL_I,0,0));
        tbl.push_back(mk(0,1,JAL_I,        0,0,0,0,0,0,0,0, 0,1,32'h10000020,JAL_I,0,0));
        // jal beats a taken branch; link = pc+4
        tbl.push_back(mk(0,0,0,            1,0,0,1,0,1,32'h999,0, 1,0,32'h10000040,JAL_I,32'h10000024,0));
        tbl.push_back(mk(0,1,32'h12345678, 0,0,0,0,0,0,0,0, 0,1,32'h10000040,32'h12345678,32'h10000024,0));
        // stall in ISSUE -> HOLD for 5 cycles; ready ignored
        tbl.push_back(mk(1,0,0,            0,0,0,0,0,0,0,0, 0,0,32'h10000044,32'h12345678,32'h10000024,0));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(1,1,32'h55555555, 0,0,0,0,0,0,0,0, 0,0,32'h10000044,32'h12345678,32'h10000024,0));
        tbl.push_back(mk(0,0,0,            0,0,0,0,0,0,0,0, 1,0,32'h10000044,32'h12345678,32'h10000024,0));

        // reset state
        rst_n = 1'b0; stall = 1'b0;
        imem_if.imem_ready = 1'b0; imem_if.imem_rdata = '0;
        Branch = 0; nBranch = 0; Jmp = 0; Jal = 0; Jr = 0; Zero = 0;
        Addr_Result = '0; Read_data_1 = '0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst req",   {31'd0, imem_if.imem_req}, 32'd0);
        chk("rst valid", {31'd0, instr_valid},      32'd0);
        chk("rst pc",    pc,                        32'h0);
        chk("rst instr", Instruction,               32'h0);
        chk("rst link",  link_addr,                 32'h0);
        chk("rst err",   {31'd0, fetch_err},        32'd0);
        @(negedge clock);
        rst_n = 1'b1;

        foreach (tbl[i])
            apply($sformatf("v%0d", i), tbl[i]);

        // reset while FETCH is active: req drops immediately
        rst_n = 1'b0;
        #1;
        chk("midrst req",   {31'd0, imem_if.imem_req}, 32'd0);
        chk("midrst pc",    pc,                        32'h0);
        chk("midrst instr", Instruction,               32'h0);
        chk("midrst link",  link_addr,                 32'h0);
        @(negedge clock);
        rst_n = 1'b1;

        // stall holds IDLE, then PC wrap through 0xFFFFFFFC
        apply("idle_stall", mk(1,0,0, 0,0,0,0,0,0,0,0, 0,0,32'h0,32'h0,0,0));
        apply("w0", mk(0,0,0,         0,0,0,0,0,0,0,0, 1,0,32'h0,32'h0,0,0));
        apply("w1", mk(0,1,32'h1,     0,0,0,0,0,0,0,0, 0,1,32'h0,32'h1,0,0));
        apply("w2", mk(0,0,0,         0,0,0,0,1,0,0,32'hFFFFFFFF, 1,0,32'hFFFFFFFC,32'h1,0,0));
        apply("w3", mk(0,1,32'h2,     0,0,0,0,0,0,0,0, 0,1,32'hFFFFFFFC,32'h2,0,0));
        apply("w4", mk(0,0,0,         0,0,0,0,0,0,0,0, 1,0,32'h0,32'h2,0,0));

        // memory never answers
        for (int k = 1; k <= 6; k++) begin
            h = mk(0,0,0, 0,0,0,0,0,0,0,0, 1,0,32'h0,32'h2,0,0);
`ifdef IFETCH_TIMEOUT_EN
            if (k >= 4) begin
                h.e_req = 0;
                h.e_err = 1;
            end
`endif
            apply($sformatf("tmo%0d", k), h);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
